// File: rtl/sfifo_ctrl_sclk.sv
// FWFT single-clock FIFO controller driving one sdpramb_sclk; a small prefetch buffer hides the RAM read latency.
// Optional sticky error flags and error counter are enabled with `define SFIFO_ERR_STICKY_EN.
module sfifo_ctrl_sclk #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTHBIT    = 9,
    parameter int RAM_OUT_REG = 1,
    parameter int AFULL_TH    = (1 << DEPTHBIT) - 8,
    parameter int AEMPTY_TH   = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [DEPTHBIT:0]     count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_enable,
    output logic                  ram_wren,
    output logic [DEPTHBIT-1:0]   ram_wraddress,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [DEPTHBIT-1:0]   ram_rdaddress,
    input  logic [DATA_WIDTH-1:0] ram_q
`ifdef SFIFO_ERR_STICKY_EN
    ,
    input  logic                  err_clr,
    output logic                  ovf_sticky,
    output logic                  udf_sticky,
    output logic [15:0]           err_cnt
`endif
);

    localparam int LAT      = (RAM_OUT_REG != 0) ? 2 : 1;
    localparam int PF_DEPTH = LAT + 1;
    localparam logic [1:0]          PF_LAST = 2'(PF_DEPTH - 1);
    localparam logic [DEPTHBIT:0]   CAP     = {1'b1, {DEPTHBIT{1'b0}}};
    localparam logic [DEPTHBIT:0]   AF_V    = AFULL_TH[DEPTHBIT:0];
    localparam logic [DEPTHBIT:0]   AE_V    = AEMPTY_TH[DEPTHBIT:0];

    logic [DEPTHBIT-1:0]   wptr;
    logic [DEPTHBIT-1:0]   rptr;
    logic [DEPTHBIT-1:0]   rd_addr_hold;
    logic [DEPTHBIT:0]     ram_cnt;
    logic [DEPTHBIT:0]     cnt_nxt;
    logic [LAT-1:0]        vld;
    logic [DATA_WIDTH-1:0] pf_mem [4];
    logic [1:0]            pf_wr;
    logic [1:0]            pf_rd;
    logic [1:0]            pf_cnt;
    logic [2:0]            inflight;
    logic [2:0]            pf_occ;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  ret;
    logic                  ovf_ev;
    logic                  udf_ev;

    // Holding reset keeps the RAM from being written even though the write path is combinational.
    assign push   = wr_en & ~full & rst_n;
    assign empty  = (pf_cnt == 2'd0);
    assign pop    = rd_en & ~empty;
    assign ovf_ev = wr_en & full;
    assign udf_ev = rd_en & empty;
    assign ret    = vld[LAT-1];

    always_comb begin
        inflight = 3'd0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + {2'b00, vld[i]};
        end
    end

    // A pop this cycle frees a prefetch slot in time for the issued read, which keeps streaming bubble-free.
    assign pf_occ = {1'b0, pf_cnt} + inflight - {2'b00, pop};
    assign issue  = (ram_cnt != '0) && (pf_occ < 3'(PF_DEPTH));

    assign cnt_nxt = count + {{DEPTHBIT{1'b0}}, push} - {{DEPTHBIT{1'b0}}, pop};

    assign ram_enable    = 1'b1;
    assign ram_wren      = push;
    assign ram_wraddress = wptr;
    assign ram_data      = wr_data;
    assign ram_rdaddress = issue ? rptr : rd_addr_hold;
    assign rd_data       = pf_mem[pf_rd];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            rd_addr_hold <= '0;
            ram_cnt      <= '0;
            vld          <= '0;
            pf_wr        <= 2'd0;
            pf_rd        <= 2'd0;
            pf_cnt       <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                pf_mem[i] <= '0;
            end
            count        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + DEPTHBIT'(1);
            end
            if (issue) begin
                rptr         <= rptr + DEPTHBIT'(1);
                rd_addr_hold <= rptr;
            end
            ram_cnt <= ram_cnt + {{DEPTHBIT{1'b0}}, push} - {{DEPTHBIT{1'b0}}, issue};

            vld[0] <= issue;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
            end

            if (ret) begin
                pf_mem[pf_wr] <= ram_q;
                pf_wr         <= (pf_wr == PF_LAST) ? 2'd0 : pf_wr + 2'd1;
            end
            if (pop) begin
                pf_rd <= (pf_rd == PF_LAST) ? 2'd0 : pf_rd + 2'd1;
            end
            pf_cnt <= pf_cnt + {1'b0, ret} - {1'b0, pop};

            count        <= cnt_nxt;
            full         <= (cnt_nxt == CAP);
            almost_full  <= (cnt_nxt >= AF_V);
            almost_empty <= (cnt_nxt <= AE_V);
            overflow     <= ovf_ev;
            underflow    <= udf_ev;
        end
    end

`ifdef SFIFO_ERR_STICKY_EN
    logic [16:0] err_sum;

    // A clear in the same cycle as an error still records that error.
    always_comb begin
        err_sum = (err_clr ? 17'd0 : {1'b0, err_cnt}) + {16'd0, ovf_ev} + {16'd0, udf_ev};
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
            err_cnt    <= 16'd0;
        end else begin
            ovf_sticky <= ovf_ev | (ovf_sticky & ~err_clr);
            udf_sticky <= udf_ev | (udf_sticky & ~err_clr);
            err_cnt    <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_sfifo_ctrl_sclk.sv
// Bench for sfifo_ctrl_sclk: two instances (2-cycle and 1-cycle RAM latency) with behavioural RAMs,
// checked against a reference queue and a count model.
module tb_sfifo_ctrl_sclk;
    localparam int DB  = 4;
    localparam int CAP = 16;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        sel = 1'b0;

    always #5 clock = ~clock;

    logic        full_a, af_a, empty_a, ae_a, ovf_a, udf_a, en_a, wren_a;
    logic [31:0] rdd_a, ramd_a, q_a;
    logic [4:0]  cnt_a;
    logic [3:0]  wa_a, ra_a;
    logic        full_b, af_b, empty_b, ae_b, ovf_b, udf_b, en_b, wren_b;
    logic [31:0] rdd_b, ramd_b, q_b;
    logic [4:0]  cnt_b;
    logic [3:0]  wa_b, ra_b;

    sfifo_ctrl_sclk #(.DATA_WIDTH(32), .DEPTHBIT(DB), .RAM_OUT_REG(1), .AFULL_TH(8), .AEMPTY_TH(4)) dut_a (
        .clock(clock), .rst_n(rst_n), .wr_en(wr_en & ~sel), .wr_data(wr_data),
        .full(full_a), .almost_full(af_a), .rd_en(rd_en & ~sel), .rd_data(rdd_a),
        .empty(empty_a), .almost_empty(ae_a), .count(cnt_a), .overflow(ovf_a), .underflow(udf_a),
        .ram_enable(en_a), .ram_wren(wren_a), .ram_wraddress(wa_a), .ram_data(ramd_a),
        .ram_rdaddress(ra_a), .ram_q(q_a));

    sfifo_ctrl_sclk #(.DATA_WIDTH(32), .DEPTHBIT(DB), .RAM_OUT_REG(0), .AFULL_TH(8), .AEMPTY_TH(4)) dut_b (
        .clock(clock), .rst_n(rst_n), .wr_en(wr_en & sel), .wr_data(wr_data),
        .full(full_b), .almost_full(af_b), .rd_en(rd_en & sel), .rd_data(rdd_b),
        .empty(empty_b), .almost_empty(ae_b), .count(cnt_b), .overflow(ovf_b), .underflow(udf_b),
        .ram_enable(en_b), .ram_wren(wren_b), .ram_wraddress(wa_b), .ram_data(ramd_b),
        .ram_rdaddress(ra_b), .ram_q(q_b));

    // Behavioural RAMs: registered read, plus an output register for instance A.
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] q1_a, q2_a, q1_b;
    always @(posedge clock) begin
        if (wren_a) mem_a[wa_a] <= ramd_a;
        q1_a <= mem_a[ra_a];
        q2_a <= q1_a;
        if (wren_b) mem_b[wa_b] <= ramd_b;
        q1_b <= mem_b[ra_b];
    end
    assign q_a = q2_a;
    assign q_b = q1_b;

    logic        o_full, o_af, o_empty, o_ae, o_ovf, o_udf, o_en, o_wren;
    logic [31:0] o_rdd;
    logic [4:0]  o_cnt;
    assign o_full  = sel ? full_b  : full_a;
    assign o_af    = sel ? af_b    : af_a;
    assign o_empty = sel ? empty_b : empty_a;
    assign o_ae    = sel ? ae_b    : ae_a;
    assign o_ovf   = sel ? ovf_b   : ovf_a;
    assign o_udf   = sel ? udf_b   : udf_a;
    assign o_en    = sel ? en_b    : en_a;
    assign o_wren  = sel ? wren_b  : wren_a;
    assign o_rdd   = sel ? rdd_b   : rdd_a;
    assign o_cnt   = sel ? cnt_b   : cnt_a;

    int          n_chk = 0;
    int          n_err = 0;
    int          mcnt  = 0;
    logic [31:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    // One clock: drive inputs, score pops/pushes, then check registered outputs after the edge.
    task automatic step(input logic we, input logic [31:0] wd, input logic re);
        logic        pop_ok, push_ok, exp_ovf, exp_udf;
        logic [31:0] exp;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        pop_ok  = re && !o_empty;
        push_ok = we && (mcnt != CAP);
        exp_ovf = we && (mcnt == CAP);
        exp_udf = re && o_empty;
        if (pop_ok) begin
            if (sb.size() > 0) exp = sb.pop_front();
            else exp = 32'hDEAD_BEEF;
            chk("rd_data", o_rdd, exp);
            mcnt--;
        end
        if (push_ok) begin
            sb.push_back(wd);
            mcnt++;
        end
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("count", 32'(o_cnt), 32'(mcnt));
        chk("full", 32'(o_full), 32'(mcnt == CAP));
        chk("almost_full", 32'(o_af), 32'(mcnt >= 8));
        chk("almost_empty", 32'(o_ae), 32'(mcnt <= 4));
        chk("overflow", 32'(o_ovf), 32'(exp_ovf));
        chk("underflow", 32'(o_udf), 32'(exp_udf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0);
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() > 0 && g < 200) begin
            step(1'b0, 32'd0, 1'b1);
            g++;
        end
        chk("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_count", 32'(o_cnt), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_aempty", 32'(o_ae), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_afull", 32'(o_af), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        chk("rst_udf", 32'(o_udf), 32'd0);
        chk("rst_rd_data", o_rdd, 32'd0);
        chk("rst_ram_enable", 32'(o_en), 32'd1);
        wr_en = 1'b1;
        #1;
        chk("rst_ram_wren", 32'(o_wren), 32'd0);
        wr_en = 1'b0;
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        // First-word latency with the 2-cycle RAM: data visible at cycle 4.
        step(1'b1, 32'h11, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("lat_empty_c3", 32'(o_empty), 32'd1);
        step(1'b0, 32'd0, 1'b0);
        chk("lat_empty_c4", 32'(o_empty), 32'd0);
        chk("lat_data_c4", o_rdd, 32'h11);
        drain();

        // Fill to capacity, overflow, then drain in order.
        for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b0);
        chk("full_after_16", 32'(o_full), 32'd1);
        step(1'b1, 32'hAA, 1'b0);
        chk("ovf_pulse", 32'(o_ovf), 32'd1);
        chk("ovf_count", 32'(o_cnt), 32'd16);
        step(1'b0, 32'd0, 1'b0);
        chk("ovf_one_cycle", 32'(o_ovf), 32'd0);
        drain();

        // Underflow from empty.
        step(1'b0, 32'd0, 1'b1);
        chk("udf_pulse", 32'(o_udf), 32'd1);
        chk("udf_empty", 32'(o_empty), 32'd1);
        step(1'b0, 32'd0, 1'b0);
        chk("udf_one_cycle", 32'(o_udf), 32'd0);

        // Streaming push+pop with four words primed, both RAM latencies.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 4; i++) step(1'b1, 32'(100 + i), 1'b0);
            idle(6);
            for (int k = 0; k < 100; k++) begin
                chk("no_bubble", 32'(o_empty), 32'd0);
                step(1'b1, 32'(104 + k), 1'b1);
            end
            chk("stream_count", 32'(o_cnt), 32'd4);
            drain();
        end

        // Wrap-around with random gaps, both RAM latencies.
        for (int s = 0; s < 2; s++) begin
            int          acc = 0;
            int          guard = 0;
            logic [31:0] wd = 32'h1000 * (s + 1);
            logic        we, re;
            sel = s[0];
            while (acc < 40 && guard < 2000) begin
                we = ($urandom_range(0, 2) != 0);
                re = ($urandom_range(0, 2) != 0);
                if (we && mcnt != CAP) acc++;
                step(we, wd, re);
                if (we) wd++;
                guard++;
            end
            chk("wrap_pushes", 32'(acc), 32'd40);
            drain();
        end

        // Asynchronous reset mid-stream.
        sel = 1'b0;
        for (int i = 0; i < 7; i++) step(1'b1, 32'(200 + i), 1'b0);
        idle(5);
        chk("pre_rst_count", 32'(o_cnt), 32'd7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(o_cnt), 32'd0);
        chk("arst_empty", 32'(o_empty), 32'd1);
        chk("arst_aempty", 32'(o_ae), 32'd1);
        chk("arst_full", 32'(o_full), 32'd0);
        chk("arst_rd_data", o_rdd, 32'd0);
        sb.delete();
        mcnt = 0;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        step(1'b1, 32'h5, 1'b0);
        idle(3);
        chk("post_rst_data", o_rdd, 32'h5);
        chk("post_rst_count", 32'(o_cnt), 32'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
